mem_stage_mc: RTL and testbench
===============================

// Module: mem_stage_mc
// PURPOSE
//  MEM pipeline stage for data memory with variable response latency (successor to the fixed 1-cycle MEM stage).
//  Registers the EX->MEM bus and waits for data_rvalid on loads, raising a stall request meanwhile.
//  Holds returned data while the pipeline is frozen, then aligns and extends it (LW/LB/LBU/LH/LHU).
//  Sits between EX and WB; drives the MEM->WB bus and stallreq_for_mem to the stall controller.
// PARAMETERS
//  PC_W        32  width of the PC field carried on both buses
//  WAIT_CNT_W  4   width of the load-wait cycle counter
//  MAX_WAIT    15  wait cycles before mem_timeout is flagged (must be < 2**WAIT_CNT_W)
// PORTS
//  clk              in   1           single clock; all state updates on posedge
//  rst              in   1           synchronous, active-high reset
//  stall            in   `StallBus   stall vector; bit 3 = MEM stage, bit 4 = WB stage
//  ex_to_mem_bus    in   PC_W+43     {sl[3:0], pc, sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}
//  data_sram_rdata  in   32          load data word, valid only when data_rvalid=1
//  data_rvalid      in   1           one-cycle pulse: load response present
//  mem_to_wb_bus    out  PC_W+38     {pc, rf_we, rf_waddr[4:0], rf_wdata[31:0]}
//  stallreq_for_mem out  1           request to freeze IF..MEM while a load is outstanding
//  mem_timeout      out  1           sticky: a load waited MAX_WAIT cycles without data_rvalid
//  mem_adel         out  1           misaligned-load flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): bus register=0, state=IDLE, hold reg=0, counter=0, mem_timeout=0.
//    Outputs after reset: mem_to_wb_bus=0, stallreq_for_mem=0, mem_adel=0. Reset mid-wait abandons the load.
//  - Bus register: stall[3]=1 & stall[4]=0 -> load zeros (bubble); stall[3]=0 -> capture ex_to_mem_bus;
//    otherwise hold.
//  - is_load = sel_rf_res & (sl in {0001,0011,0100,0101,0110}).
//  - FSM:
//    IDLE: is_load & !data_rvalid -> WAIT, counter=1.
//          is_load & data_rvalid & stall[3] -> HOLD, capture rdata.
//          else stay.
//    WAIT: data_rvalid -> capture rdata; go HOLD if stall[3] still set next cycle, else IDLE.
//          no rvalid -> counter++ (saturates); counter==MAX_WAIT sets mem_timeout.
//    HOLD: stays until the bus register advances (stall[3]=0), then IDLE; hold reg cleared.
//  - stallreq_for_mem = is_load & (state!=HOLD) & !data_rvalid  (combinational; 0-wait loads never stall).
//  - data_rvalid in IDLE without is_load is ignored; a second rvalid in HOLD is ignored.
//  - Data source: rdata_sel = data_rvalid ? data_sram_rdata : hold reg.
//  - Load alignment on ex_result[1:0] (a):
//      LW: word.
//      LB/LBU: byte a, sign/zero-extended.
//      LH/LHU: half a[1], sign/zero-extended when a[0]=0.
//  - Non-load ops pass ex_result. Output latency: 0 cycles after data available; bus is combinational from regs.
//  - rf_we on mem_to_wb_bus forced 0 while stallreq_for_mem=1 (no partial write to WB).
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    LW with a!=00, or LH/LHU with a[0]=1 -> mem_adel=1 and rf_we forced 0.
//    No wait is entered; stallreq_for_mem=0 for that op.
//  MEM_ALIGN_CHECK_EN undefined:
//    mem_adel tied 0; misaligned LW returns the raw word; misaligned LH/LHU returns ex_result.
// TESTING
//  1. ALU op, ex_result=0x1234_5678, rf_we=1, waddr=5 -> next cycle WB bus carries 0x12345678, we=1, no stall.
//  2. LB, a=01, rvalid same cycle, rdata=0x0000_8000 -> rf_wdata=0xFFFF_FF80, stallreq=0.
//  3. LHU, a=10, rvalid after 3 cycles, rdata=0xBEEF_0000 -> stallreq=1 for 3 cycles; then 0x0000_BEEF.
//  4. LW; rvalid arrives while stall[4:3]=11; rdata=0xCAFE_F00D -> HOLD; 2 cycles later stall clears,
//     WB gets 0xCAFEF00D.
//  5. LW with no rvalid for 15 cycles -> mem_timeout=1 and stays 1; rst=1 clears it, state=IDLE.
//  6. (MEM_ALIGN_CHECK_EN) LH, a=01 -> mem_adel=1, rf_we=0, stallreq=0.

Source files
------------

// File: rtl/mem_stage_mc.sv
// MEM stage for a data memory with variable load latency: waits on data_rvalid, holds data across freezes, aligns loads.
// Optional MEM_ALIGN_CHECK_EN: flags misaligned LW/LH/LHU on mem_adel and suppresses their write-back.
module mem_stage_mc #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned WAIT_CNT_W = 4,
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned STALL_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic [PC_W+42:0]     ex_to_mem_bus,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 data_rvalid,
    output logic [PC_W+37:0]     mem_to_wb_bus,
    output logic                 stallreq_for_mem,
    output logic                 mem_timeout,
    output logic                 mem_adel
);

    localparam int unsigned EX_W = PC_W + 43;

    localparam logic [3:0] SL_LW  = 4'b0001;
    localparam logic [3:0] SL_LB  = 4'b0011;
    localparam logic [3:0] SL_LBU = 4'b0100;
    localparam logic [3:0] SL_LH  = 4'b0101;
    localparam logic [3:0] SL_LHU = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [EX_W-1:0]       bus_q, bus_d;
    logic [31:0]           hold_q, hold_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    logic [3:0]      sl;
    logic [PC_W-1:0] pc;
    logic            sel_rf_res;
    logic            rf_we_raw;
    logic [4:0]      rf_waddr;
    logic [31:0]     ex_result;
    logic [1:0]      addr_lo;

    assign sl         = bus_q[EX_W-1 -: 4];
    assign pc         = bus_q[PC_W+38:39];
    assign sel_rf_res = bus_q[38];
    assign rf_we_raw  = bus_q[37];
    assign rf_waddr   = bus_q[36:32];
    assign ex_result  = bus_q[31:0];
    assign addr_lo    = ex_result[1:0];

    // Stall bits other than MEM/WB are not used by this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[2:0], stall[STALL_W-1:5]};

    logic is_lw, is_lb, is_lbu, is_lh, is_lhu, is_load;
    assign is_lw   = sel_rf_res & (sl == SL_LW);
    assign is_lb   = sel_rf_res & (sl == SL_LB);
    assign is_lbu  = sel_rf_res & (sl == SL_LBU);
    assign is_lh   = sel_rf_res & (sl == SL_LH);
    assign is_lhu  = sel_rf_res & (sl == SL_LHU);
    assign is_load = is_lw | is_lb | is_lbu | is_lh | is_lhu;

    logic adel_c;
`ifdef MEM_ALIGN_CHECK_EN
    assign adel_c = (is_lw & (addr_lo != 2'b00)) | ((is_lh | is_lhu) & addr_lo[0]);
`else
    assign adel_c = 1'b0;
`endif

    // A misaligned load (when checked) never talks to memory, so it neither waits nor stalls.
    logic load_act;
    assign load_act = is_load & ~adel_c;

    logic stallreq_c;
    assign stallreq_c = load_act & (state_q != S_HOLD) & ~data_rvalid;

    // A late rvalid while holding is ignored; the held word stays authoritative.
    logic [31:0] rdata_sel;
    assign rdata_sel = (data_rvalid && state_q != S_HOLD) ? data_sram_rdata : hold_q;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wdata;

    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo)
            2'b00:   ld_byte = rdata_sel[7:0];
            2'b01:   ld_byte = rdata_sel[15:8];
            2'b10:   ld_byte = rdata_sel[23:16];
            default: ld_byte = rdata_sel[31:24];
        endcase
        ld_half = addr_lo[1] ? rdata_sel[31:16] : rdata_sel[15:0];

        wdata = ex_result;
        if (is_lw) begin
            wdata = rdata_sel;
        end else if (is_lb | is_lbu) begin
            wdata = {{24{is_lb & ld_byte[7]}}, ld_byte};
        end else if ((is_lh | is_lhu) && !addr_lo[0]) begin
            wdata = {{16{is_lh & ld_half[15]}}, ld_half};
        end
    end

    // EX->MEM register: bubble when MEM freezes but WB drains, capture when MEM advances.
    always_comb begin
        bus_d = bus_q;
        if (stall[3] && !stall[4]) begin
            bus_d = '0;
        end else if (!stall[3]) begin
            bus_d = ex_to_mem_bus;
        end
    end

    // Load handshake FSM plus wait counter and sticky timeout.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (load_act && !data_rvalid) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_CNT_W'(1);
                end else if (load_act && data_rvalid && stall[3]) begin
                    state_d = S_HOLD;
                    hold_d  = data_sram_rdata;
                end
            end
            S_WAIT: begin
                if (!load_act) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (data_rvalid) begin
                    cnt_d = '0;
                    if (stall[3]) begin
                        state_d = S_HOLD;
                        hold_d  = data_sram_rdata;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q != {WAIT_CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + WAIT_CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (!stall[3]) begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_WAIT && cnt_d == WAIT_CNT_W'(MAX_WAIT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bus_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_to_wb_bus    = {pc, rf_we_raw & ~stallreq_c & ~adel_c, rf_waddr, wdata};
    assign stallreq_for_mem = stallreq_c;
    assign mem_timeout      = timeout_q;
    assign mem_adel         = adel_c;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Scoreboard bench for mem_stage_mc: stimulus queues hand-computed per-cycle outputs, a negedge monitor compares.
module tb_mem_stage_mc;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [74:0]  ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         data_rvalid;
    logic [69:0]  mem_to_wb_bus;
    logic         stallreq_for_mem;
    logic         mem_timeout;
    logic         mem_adel;

    mem_stage_mc dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_rvalid      (data_rvalid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .stallreq_for_mem (stallreq_for_mem),
        .mem_timeout      (mem_timeout),
        .mem_adel         (mem_adel)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] SL_ALU = 4'b0000;
    localparam logic [3:0] SL_LW  = 4'b0001;
    localparam logic [3:0] SL_LB  = 4'b0011;
    localparam logic [3:0] SL_LBU = 4'b0100;
    localparam logic [3:0] SL_LH  = 4'b0101;
    localparam logic [3:0] SL_LHU = 4'b0110;

    localparam logic [5:0] ST_RUN  = 6'b000000;
    localparam logic [5:0] ST_WAIT = 6'b011111;
    localparam logic [5:0] ST_FRZ  = 6'b011000;

    typedef struct packed {
        logic [69:0] wb;
        logic        sreq;
        logic        to;
        logic        adel;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [74:0] mk_ex(input logic [3:0] sl, input logic [31:0] pc, input logic sel,
                                          input logic we, input logic [4:0] wa, input logic [31:0] res);
        return {sl, pc, sel, we, wa, res};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                          input logic [31:0] d);
        return {pc, we, wa, d};
    endfunction

    task automatic step(input logic [5:0] st, input logic [74:0] ex, input logic rv, input logic [31:0] rd,
                        input logic chk, input logic [69:0] wb, input logic sr, input logic to,
                        input logic ad, input string nm);
        exp_t e;
        stall           = st;
        ex_to_mem_bus   = ex;
        data_rvalid     = rv;
        data_sram_rdata = rd;
        if (chk) begin
            e.wb   = wb;
            e.sreq = sr;
            e.to   = to;
            e.adel = ad;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if ({mem_to_wb_bus, stallreq_for_mem, mem_timeout, mem_adel} !== e) begin
                errors++;
                $display("FAIL %s: got wb=%h sreq=%b to=%b adel=%b, want wb=%h sreq=%b to=%b adel=%b",
                         nm, mem_to_wb_bus, stallreq_for_mem, mem_timeout, mem_adel,
                         e.wb, e.sreq, e.to, e.adel);
            end
        end
    end

    logic [74:0] alu1, ld_b, ld_hu, ld_w, alu2, ld_h_mis, ld_bu, ld_h, ld_w2, alu3;

    initial begin
        alu1     = mk_ex(SL_ALU, 32'h100, 1'b0, 1'b1, 5'd5,  32'h1234_5678);
        ld_b     = mk_ex(SL_LB,  32'h104, 1'b1, 1'b1, 5'd6,  32'h0000_1001);
        ld_hu    = mk_ex(SL_LHU, 32'h108, 1'b1, 1'b1, 5'd7,  32'h0000_2002);
        ld_w     = mk_ex(SL_LW,  32'h10C, 1'b1, 1'b1, 5'd8,  32'h0000_3000);
        alu2     = mk_ex(SL_ALU, 32'h110, 1'b0, 1'b1, 5'd9,  32'hA5A5_A5A5);
        ld_h_mis = mk_ex(SL_LH,  32'h114, 1'b1, 1'b1, 5'd10, 32'h0000_4001);
        ld_bu    = mk_ex(SL_LBU, 32'h118, 1'b1, 1'b1, 5'd11, 32'h0000_5003);
        ld_h     = mk_ex(SL_LH,  32'h11C, 1'b1, 1'b1, 5'd12, 32'h0000_6002);
        ld_w2    = mk_ex(SL_LW,  32'h120, 1'b1, 1'b1, 5'd13, 32'h0000_7000);
        alu3     = mk_ex(SL_ALU, 32'h130, 1'b0, 1'b1, 5'd14, 32'h0BAD_F00D);

        rst = 1'b1; stall = ST_RUN; ex_to_mem_bus = '0; data_rvalid = 1'b0; data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step(ST_RUN, alu1, 1'b0, 32'h0, 1'b1, 70'h0, 1'b0, 1'b0, 1'b0, "reset_state");
        step(ST_RUN, ld_b, 1'b0, 32'h0, 1'b1, mk_wb(32'h100, 1'b1, 5'd5, 32'h1234_5678), 1'b0, 1'b0, 1'b0, "alu_pass");
        step(ST_RUN, ld_hu, 1'b1, 32'h0000_8000, 1'b1, mk_wb(32'h104, 1'b1, 5'd6, 32'hFFFF_FF80), 1'b0, 1'b0, 1'b0, "lb_zero_wait");
        for (int k = 0; k < 3; k++)
            step(ST_WAIT, ld_hu, 1'b0, 32'h0, 1'b1, mk_wb(32'h108, 1'b0, 5'd7, 32'h0), 1'b1, 1'b0, 1'b0, "lhu_waiting");
        step(ST_RUN, ld_w, 1'b1, 32'hBEEF_0000, 1'b1, mk_wb(32'h108, 1'b1, 5'd7, 32'h0000_BEEF), 1'b0, 1'b0, 1'b0, "lhu_data");
        step(ST_FRZ, alu2, 1'b1, 32'hCAFE_F00D, 1'b1, mk_wb(32'h10C, 1'b1, 5'd8, 32'hCAFE_F00D), 1'b0, 1'b0, 1'b0, "lw_rvalid_frozen");
        step(ST_FRZ, alu2, 1'b1, 32'hDEAD_BEEF, 1'b1, mk_wb(32'h10C, 1'b1, 5'd8, 32'hCAFE_F00D), 1'b0, 1'b0, 1'b0, "hold_ignore_rvalid");
        step(ST_FRZ, alu2, 1'b0, 32'h0, 1'b1, mk_wb(32'h10C, 1'b1, 5'd8, 32'hCAFE_F00D), 1'b0, 1'b0, 1'b0, "hold_frozen");
        step(ST_RUN, alu2, 1'b0, 32'h0, 1'b1, mk_wb(32'h10C, 1'b1, 5'd8, 32'hCAFE_F00D), 1'b0, 1'b0, 1'b0, "hold_release");
        step(ST_RUN, ld_h_mis, 1'b0, 32'h0, 1'b1, mk_wb(32'h110, 1'b1, 5'd9, 32'hA5A5_A5A5), 1'b0, 1'b0, 1'b0, "alu_after_hold");
`ifdef MEM_ALIGN_CHECK_EN
        step(ST_RUN, ld_bu, 1'b0, 32'h0, 1'b1, mk_wb(32'h114, 1'b0, 5'd10, 32'h0000_4001), 1'b0, 1'b0, 1'b1, "lh_misaligned_adel");
`else
        step(ST_RUN, ld_bu, 1'b1, 32'h1111_2222, 1'b1, mk_wb(32'h114, 1'b1, 5'd10, 32'h0000_4001), 1'b0, 1'b0, 1'b0, "lh_misaligned_raw");
`endif
        step(ST_RUN, ld_h, 1'b1, 32'h9A00_0000, 1'b1, mk_wb(32'h118, 1'b1, 5'd11, 32'h0000_009A), 1'b0, 1'b0, 1'b0, "lbu_byte3");
        step(ST_RUN, ld_w2, 1'b1, 32'h8001_7FFF, 1'b1, mk_wb(32'h11C, 1'b1, 5'd12, 32'hFFFF_8001), 1'b0, 1'b0, 1'b0, "lh_signed_hi");
        // Timeout asserts once 15 consecutive cycles have passed without rvalid.
        for (int k = 1; k <= 17; k++)
            step(ST_WAIT, alu3, 1'b0, 32'h0, 1'b1, mk_wb(32'h120, 1'b0, 5'd13, 32'h0), 1'b1, (k >= 16), 1'b0, "lw_timeout");
        rst = 1'b1;
        step(ST_WAIT, alu3, 1'b0, 32'h0, 1'b0, 70'h0, 1'b0, 1'b0, 1'b0, "");
        rst = 1'b0;
        step(ST_RUN, alu3, 1'b0, 32'h0, 1'b1, 70'h0, 1'b0, 1'b0, 1'b0, "reset_clears");
        step(ST_RUN, '0, 1'b0, 32'h0, 1'b1, mk_wb(32'h130, 1'b1, 5'd14, 32'h0BAD_F00D), 1'b0, 1'b0, 1'b0, "idle_after_reset");
        step(ST_RUN, '0, 1'b0, 32'h0, 1'b0, 70'h0, 1'b0, 1'b0, 1'b0, "");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
